// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM encoding,
// datapath widths and the baud divisor computation.
package uart_pkg;

  localparam int BAUD_WIDTH = 16;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Truncating divide; the remainder is dropped, never accumulated.
  function automatic logic [BAUD_WIDTH-1:0] clks_per_baud(input int unsigned clk_freq,
                                                          input int unsigned baud_rate);
    return BAUD_WIDTH'(clk_freq / baud_rate);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO; read data is the current head, available
// combinationally so a pop captures it in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign wr_en   = wr_i & ~full_o;
  assign rd_en   = rd_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO; back-to-back frames have no idle gap.
// Define UART_TX_PARITY_EN to insert an even parity bit (11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 65000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [7:0]  data_i,
  output logic        full_o,
  output logic        busy_o,
  output logic        uart_tx_o,
  output uart_state_e dbg_state_o
);

  localparam logic [BAUD_WIDTH-1:0] CPB       = clks_per_baud(CLK_FREQ, BAUD_RATE);
  localparam logic [BAUD_WIDTH-1:0] BAUD_LAST = CPB - BAUD_WIDTH'(1);

  uart_state_e           state_q, state_d;
  logic [BAUD_WIDTH-1:0] baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  line_q, line_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  fifo_rd, fifo_empty, baud_wrap;
  logic [DATA_WIDTH-1:0] fifo_data;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (wr_i),
    .data_i  (data_i),
    .rd_i    (fifo_rd),
    .data_o  (fifo_data),
    .full_o  (full_o),
    .empty_o (fifo_empty)
  );

  assign baud_wrap   = (baud_q == BAUD_LAST);
  assign busy_o      = (state_q != IDLE) | ~fifo_empty;
  assign uart_tx_o   = line_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    fifo_rd = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + BAUD_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_data;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_data;
`endif
          state_d = START;
        end
      end
      START: if (baud_wrap) state_d = DATA;
      DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_wrap) state_d = STOP;
`endif
      STOP: begin
        // Popping here chains the next start bit with no idle clock.
        if (baud_wrap) begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            shift_d = fifo_data;
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_data;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line is derived from the next state so the register lines up with state_q.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit-side counterpart of the design's UART receiver; serializes bytes from the host logic onto a single TX line as 8N1 frames. An optional even-parity bit is added when compiled in. A small FIFO decouples single-cycle byte writes from the slow serial line and allows back-to-back frames with no idle gap.

## Interface
- CLK_FREQ, 65000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- FIFO_DEPTH, 4: byte entries, power of two, 2..16.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_i  in  1  byte write strobe, one cycle per byte.
- data_i  in  8  byte to send, sampled with wr_i.
- full_o  out  1  FIFO full; writes ignored while high.
- busy_o  out  1  high while a frame is on the line or the FIFO is non-empty.
- uart_tx_o  out  1  serial line, idles high.

## Operation
- CLKS_PER_BAUD = CLK_FREQ/BAUD_RATE, truncated integer, 16-bit; 564 at the defaults. Baud counter counts 0..CLKS_PER_BAUD-1, wraps to 0, and is held at 0 in IDLE.
- Write is accepted when wr_i=1 and full_o=0 at the edge. The write is silently dropped when full_o=1, even if a pop occurs in the same cycle.
- Simultaneous write and pop on a non-empty FIFO: the count is unchanged and both take effect.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: line 0 for one baud period, then go to DATA.
  - DATA: drive shift[0] (LSB first) for one baud period per bit. Shift right at each wrap. A 3-bit bit counter moves to PARITY/STOP after bit 7.
  - PARITY: line = even parity of the byte (XOR of 8 bits, latched at pop) for one baud period.
  - STOP: line 1 for one full baud period. At the wrap, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- uart_tx_o is registered, so there are no glitches.
- Reset, including mid-frame:
  - uart_tx_o=1, busy_o=0, full_o=0.
  - FIFO emptied, baud/bit counters 0, state IDLE.
  - Any partial frame is truncated.
- busy_o = (state!=IDLE) | fifo_not_empty.

## Timing
- wr_i high at edge E0 with the FIFO empty and the FSM in IDLE:
  - FIFO non-empty after E0.
  - Pop at E0+1; uart_tx_o falls after E0+1.
  - Start-bit-to-line latency is 2 cycles from the strobe edge.
- Frame length: 10×CLKS_PER_BAUD clocks, or 11× with parity. Back-to-back frames have zero idle clocks between the stop bit and the next start bit.
- full_o updates the cycle after the write that fills the last entry, and drops the cycle after a pop.
- busy_o falls the cycle after the last stop-bit period ends with the FIFO empty.
- Each bit period is exactly CLKS_PER_BAUD clocks. There is no accumulated drift beyond truncation of CLKS_PER_BAUD.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, even parity bit between bit 7 and stop, 11-bit frame. The receiver must be built with parity on.
- Not defined: PARITY state and parity logic absent; 10-bit 8N1 frame.

## Structure
- Shared package uart_pkg, shared with the receiver:
  - state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit;
  - BAUD_WIDTH=16 and DATA_WIDTH=8;
  - the CLKS_PER_BAUD computation.
- One sub-module: uart_tx_fifo, a synchronous single-clock FIFO.
  - Interface: wr/rd/data/full/empty.
  - Reset via rst_i.
  - Read data is valid combinationally at the head, so a pop captures the head in the same cycle.

## Test plan
Bench uses CLK_FREQ=1000000, BAUD_RATE=100000, i.e. 10 clocks/baud.
- Single byte 0xA5 from idle:
  - line sequence 0,1,0,1,0,0,1,0,1,1, each exactly 10 clocks;
  - start edge 2 cycles after wr_i;
  - busy_o low afterward.
- Write 0x00, 0xFF, 0x3C on consecutive cycles: three contiguous frames with no idle gap; full_o never asserts at depth 4.
- Write 6 bytes 0x01..0x06 in 6 consecutive cycles:
  - full_o asserts;
  - the byte written while full_o is high is dropped;
  - exactly the accepted bytes appear on the line, in order.
- Assert rst_i during bit 3 of 0x55:
  - uart_tx_o=1 the cycle after;
  - busy_o=0, full_o=0;
  - queued bytes are discarded and not sent.
- With UART_TX_PARITY_EN, send 0x07: parity bit 1, 11-bit frame, 110 clocks. Send 0x03: parity bit 0.
- Loopback into the UART receiver at matching parameters: 256 bytes 0x00..0xFF are received in order with no errors.
